// File: rtl/temperature_sample_ctrl_pkg.sv
// Shared definitions for the greenhouse temperature sampling controller.
//   NR_SENSORS / DATA_W : sensor channel count and reading width
//   SUM_W               : accumulator, dividend, quotient and remainder width
//   CNT_W               : active-sensor count width
//   state_e             : sequencing FSM states
//   sensor_slice()      : extracts one reading from the packed sensor bus
package temp_pkg;

  localparam int unsigned NR_SENSORS = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SUM_W      = 16;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned IDX_W      = $clog2(NR_SENSORS);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ACCUM,
    DIVIDE,
    DONE
  } state_e;

  // Sensor k occupies bits [DATA_W*k +: DATA_W] of the packed bus.
  function automatic logic [DATA_W-1:0] sensor_slice(
    input logic [NR_SENSORS*DATA_W-1:0] data,
    input int unsigned                  k
  );
    return data[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/temperature_sample_ctrl_if.sv
// Bus bundle between the temperature datapath/display stage and the
// sampling controller.
//   slave  : controller side (samples sensors, drives results)
//   master : environment side (drives sensors/requests, consumes results)
// Signals:
//   sensors_data_i  packed sensor readings, sensor k at [8k+7:8k]
//   sensors_en_i    per-sensor enable
//   start_i         manual sample request
//   auto_en_i       periodic sampling enable
//   busy_o          controller is not idle
//   valid_o         one-cycle strobe, new results present
//   temp_q_o        average quotient
//   temp_r_o        average remainder
//   nr_active_o     active sensor count of the last sample
//   no_sensor_o     last sample had no active sensor
//   overrun_o       periodic tick dropped because the controller was busy
interface temperature_sample_ctrl_if;
  import temp_pkg::*;

  logic [NR_SENSORS*DATA_W-1:0] sensors_data_i;
  logic [NR_SENSORS-1:0]        sensors_en_i;
  logic                         start_i;
  logic                         auto_en_i;
  logic                         busy_o;
  logic                         valid_o;
  logic [SUM_W-1:0]             temp_q_o;
  logic [SUM_W-1:0]             temp_r_o;
  logic [CNT_W-1:0]             nr_active_o;
  logic                         no_sensor_o;
  logic                         overrun_o;

  modport slave (
    input  sensors_data_i,
    input  sensors_en_i,
    input  start_i,
    input  auto_en_i,
    output busy_o,
    output valid_o,
    output temp_q_o,
    output temp_r_o,
    output nr_active_o,
    output no_sensor_o,
    output overrun_o
  );

  modport master (
    output sensors_data_i,
    output sensors_en_i,
    output start_i,
    output auto_en_i,
    input  busy_o,
    input  valid_o,
    input  temp_q_o,
    input  temp_r_o,
    input  nr_active_o,
    input  no_sensor_o,
    input  overrun_o
  );

endinterface

// File: rtl/temperature_sample_ctrl_serial_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, MSB first.
// Fixed latency: start_i loads the operands; done_o is high during the
// SUM_W-th iteration cycle, with quot_o/rem_o carrying that iteration's
// final result so the caller can register it on the same edge.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        load dividend/divisor and begin (divisor must be non-zero)
//   dividend_i     dividend
//   divisor_i      divisor
//   done_o         last iteration in progress, results valid
//   quot_o         quotient
//   rem_o          remainder
module serial_divider
  import temp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [SUM_W-1:0] divisor_i,
  output logic             done_o,
  output logic [SUM_W-1:0] quot_o,
  output logic [SUM_W-1:0] rem_o
);

  localparam int unsigned ITER_W = $clog2(SUM_W);

  logic              run_q;
  logic [ITER_W-1:0] iter_q;
  logic [SUM_W-1:0]  quo_q;
  logic [SUM_W-1:0]  rem_q;
  logic [SUM_W-1:0]  dsr_q;

  logic [SUM_W:0]    rem_sh;
  logic              fits;
  logic [SUM_W-1:0]  rem_nx;
  logic [SUM_W-1:0]  quo_nx;

  // The dividend is shifted out of the quotient register as quotient bits
  // are shifted in, so one register serves both roles.
  always_comb begin
    rem_sh = {rem_q, quo_q[SUM_W-1]};
    fits   = (rem_sh >= {1'b0, dsr_q});
    rem_nx = fits ? SUM_W'(rem_sh - {1'b0, dsr_q}) : rem_sh[SUM_W-1:0];
    quo_nx = {quo_q[SUM_W-2:0], fits};
  end

  assign done_o = run_q && (iter_q == ITER_W'(SUM_W - 1));
  assign quot_o = quo_nx;
  assign rem_o  = rem_nx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      iter_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      iter_q <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dsr_q  <= divisor_i;
    end else if (run_q) begin
      quo_q  <= quo_nx;
      rem_q  <= rem_nx;
      iter_q <= iter_q + ITER_W'(1);
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/temperature_sample_ctrl.sv
// Sequencing controller for the greenhouse temperature datapath.
// On a manual request or periodic tick it snapshots the sensor readings and
// enables, accumulates the enabled readings one per cycle, divides the sum
// by the active count, and presents quotient/remainder with a one-cycle
// valid strobe.
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     temperature_sample_ctrl_if.slave (sensors, requests, results)
// Parameter:
//   PERIOD  clock cycles between automatic samples (>= 32)
module temperature_sample_ctrl
  import temp_pkg::*;
#(
  parameter int unsigned PERIOD = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  temperature_sample_ctrl_if.slave bus
);

  if (PERIOD < 32) begin : g_period_chk
    $error("temperature_sample_ctrl: PERIOD must be >= 32");
  end

  localparam int unsigned PER_W = $clog2(PERIOD);

  state_e                       state_q,     state_d;
  logic [IDX_W-1:0]             idx_q,       idx_d;
  logic [NR_SENSORS*DATA_W-1:0] snap_data_q, snap_data_d;
  logic [NR_SENSORS-1:0]        snap_en_q,   snap_en_d;
  logic [SUM_W-1:0]             sum_q,       sum_d;
  logic [CNT_W-1:0]             cnt_q,       cnt_d;
  logic [SUM_W-1:0]             res_q_q,     res_q_d;
  logic [SUM_W-1:0]             res_r_q,     res_r_d;
  logic [CNT_W-1:0]             nr_q,        nr_d;
  logic                         nosens_q,    nosens_d;
  logic                         ovr_q,       ovr_d;
  logic [PER_W-1:0]             per_q,       per_d;

  logic             tick;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_divisor;
  logic [SUM_W-1:0] div_quot;
  logic [SUM_W-1:0] div_rem;

  // Period counter runs regardless of FSM state; held at zero when disabled.
  assign tick = bus.auto_en_i && (per_q == PER_W'(PERIOD - 1));

  always_comb begin
    per_d = '0;
    if (bus.auto_en_i) begin
      per_d = tick ? '0 : per_q + PER_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_data_d = snap_data_q;
    snap_en_d   = snap_en_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    res_q_d     = res_q_q;
    res_r_d     = res_r_q;
    nr_d        = nr_q;
    nosens_d    = nosens_q;
    div_start   = 1'b0;
    // A tick that lands while not idle is dropped and flagged.
    ovr_d       = tick && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.start_i || tick) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        snap_data_d = bus.sensors_data_i;
        snap_en_d   = bus.sensors_en_i;
        sum_d       = '0;
        cnt_d       = '0;
        idx_d       = '0;
        state_d     = ACCUM;
      end

      ACCUM: begin
        if (snap_en_q[idx_q]) begin
          sum_d = sum_q + SUM_W'(sensor_slice(snap_data_q, int'(idx_q)));
          cnt_d = cnt_q + CNT_W'(1);
        end
        // The divider is launched from the combinational sum/count so the
        // last channel's contribution is included without an extra cycle.
        if (idx_q == IDX_W'(NR_SENSORS - 1)) begin
          if (cnt_d == '0) begin
            res_q_d  = '0;
            res_r_d  = '0;
            nr_d     = '0;
            nosens_d = 1'b1;
            state_d  = DONE;
          end else begin
            div_start = 1'b1;
            state_d   = DIVIDE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DIVIDE: begin
        if (div_done) begin
          res_q_d  = div_quot;
          res_r_d  = div_rem;
          nr_d     = cnt_q;
          nosens_d = 1'b0;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign div_divisor = SUM_W'(cnt_d);

  serial_divider u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (div_start),
    .dividend_i (sum_d),
    .divisor_i  (div_divisor),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_data_q <= '0;
      snap_en_q   <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      res_q_q     <= '0;
      res_r_q     <= '0;
      nr_q        <= '0;
      nosens_q    <= 1'b0;
      ovr_q       <= 1'b0;
      per_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_data_q <= snap_data_d;
      snap_en_q   <= snap_en_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      res_q_q     <= res_q_d;
      res_r_q     <= res_r_d;
      nr_q        <= nr_d;
      nosens_q    <= nosens_d;
      ovr_q       <= ovr_d;
      per_q       <= per_d;
    end
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.valid_o     = (state_q == DONE);
  assign bus.temp_q_o    = res_q_q;
  assign bus.temp_r_o    = res_r_q;
  assign bus.nr_active_o = nr_q;
  assign bus.no_sensor_o = nosens_q;
  assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_temperature_sample_ctrl.sv
module tb_temperature_sample_ctrl;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  n;
    logic        ns;
    int          at_edge;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ecnt;
  int   nchecks;
  int   nfail;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   ov_a_cnt;
  int   ov_b_cnt;
  int   ov_b_edge;

  temperature_sample_ctrl_if ifa ();
  temperature_sample_ctrl_if ifb ();

  temperature_sample_ctrl #(.PERIOD(40)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifa)
  );

  temperature_sample_ctrl #(.PERIOD(32)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ecnt = 0;
  always @(posedge clk) ecnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference average: plain sum/count over enabled channels.
  function automatic exp_t model(input logic [39:0] d, input logic [4:0] en, input int t0);
    exp_t m;
    int   s;
    int   n;
    logic [7:0] b;
    s = 0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      b = d[8*k +: 8];
      if (en[k]) begin
        s += int'(b);
        n++;
      end
    end
    m.n  = 8'(n);
    m.ns = (n == 0);
    m.q  = (n == 0) ? 16'd0 : 16'(s / n);
    m.r  = (n == 0) ? 16'd0 : 16'(s % n);
    m.at_edge = t0 + ((n == 0) ? 6 : 22);
    return m;
  endfunction

  always @(negedge clk) begin
    if (ifa.valid_o) begin
      chk("a_valid_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_latency_edge", ecnt, ea.at_edge);
        chk("a_temp_q", ifa.temp_q_o, ea.q);
        chk("a_temp_r", ifa.temp_r_o, ea.r);
        chk("a_nr_active", ifa.nr_active_o, ea.n);
        chk("a_no_sensor", ifa.no_sensor_o, ea.ns);
      end
    end
    if (ifb.valid_o) begin
      chk("b_valid_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_latency_edge", ecnt, eb.at_edge);
        chk("b_temp_q", ifb.temp_q_o, eb.q);
        chk("b_temp_r", ifb.temp_r_o, eb.r);
        chk("b_nr_active", ifb.nr_active_o, eb.n);
        chk("b_no_sensor", ifb.no_sensor_o, eb.ns);
      end
    end
    if (ifa.overrun_o) ov_a_cnt++;
    if (ifb.overrun_o) begin
      ov_b_cnt++;
      ov_b_edge = ecnt;
    end
  end

  // Called just after a rising edge; the next edge samples start_i (edge 0).
  task automatic start_a(input bit push_exp);
    int t0;
    t0 = ecnt + 1;
    if (push_exp) qa.push_back(model(ifa.sensors_data_i, ifa.sensors_en_i, t0));
    ifa.start_i = 1'b1;
    @(posedge clk); #1;
    ifa.start_i = 1'b0;
    chk("a_busy_after_trigger", ifa.busy_o, 1);
  endtask

  task automatic wait_idle_a(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!ifa.busy_o) break;
      @(posedge clk); #1;
    end
    chk(tag, ifa.busy_o, 0);
  endtask

  task automatic wait_idle_b(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!ifb.busy_o) break;
      @(posedge clk); #1;
    end
    chk(tag, ifb.busy_o, 0);
  endtask

  task automatic wait_busy_a(input string tag, output int e);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ifa.busy_o) break;
    end
    chk(tag, ifa.busy_o, 1);
    e = ecnt;
  endtask

  initial begin
    int bedge[3];
    int p;
    nchecks   = 0;
    nfail     = 0;
    ov_a_cnt  = 0;
    ov_b_cnt  = 0;
    ov_b_edge = -1;
    rst_n = 1'b0;
    ifa.sensors_data_i = '0; ifa.sensors_en_i = '0; ifa.start_i = 1'b0; ifa.auto_en_i = 1'b0;
    ifb.sensors_data_i = '0; ifb.sensors_en_i = '0; ifb.start_i = 1'b0; ifb.auto_en_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ifa.busy_o, 0);
    chk("rst_valid", ifa.valid_o, 0);
    chk("rst_temp_q", ifa.temp_q_o, 0);
    chk("rst_temp_r", ifa.temp_r_o, 0);
    chk("rst_nr_active", ifa.nr_active_o, 0);
    chk("rst_no_sensor", ifa.no_sensor_o, 0);
    chk("rst_overrun", ifa.overrun_o, 0);
    chk("rst_b_busy", ifb.busy_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all sensors, 20..28
    ifa.sensors_data_i = {8'd28, 8'd26, 8'd24, 8'd22, 8'd20};
    ifa.sensors_en_i   = 5'b11111;
    start_a(1'b1);
    wait_idle_a("idle_s1");

    // 2: two sensors, odd remainder
    ifa.sensors_data_i = {8'd99, 8'd77, 8'd30, 8'd55, 8'd25};
    ifa.sensors_en_i   = 5'b00101;
    start_a(1'b1);
    wait_idle_a("idle_s2");

    // 3: no active sensor
    ifa.sensors_en_i = 5'b00000;
    start_a(1'b1);
    wait_idle_a("idle_s3");

    // 4: inputs change after capture; the snapshot must win
    ifa.sensors_data_i = {5{8'd255}};
    ifa.sensors_en_i   = 5'b11111;
    start_a(1'b1);
    @(posedge clk); #1;
    ifa.sensors_data_i = '0;
    ifa.sensors_en_i   = 5'b00001;
    wait_idle_a("idle_s4");

    // 5a: periodic sampling every 40 cycles, manual start while busy ignored
    ifa.sensors_data_i = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    ifa.sensors_en_i   = 5'b11111;
    ifa.auto_en_i      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_busy_a("auto_busy", bedge[i]);
      qa.push_back(model(ifa.sensors_data_i, ifa.sensors_en_i, bedge[i]));
      if (i == 0) begin
        repeat (5) @(posedge clk);
        #1;
        ifa.start_i = 1'b1;
        @(posedge clk); #1;
        ifa.start_i = 1'b0;
      end
      wait_idle_a("auto_idle");
    end
    ifa.auto_en_i = 1'b0;
    chk("auto_period_1", bedge[1] - bedge[0], 40);
    chk("auto_period_2", bedge[2] - bedge[1], 40);

    // 5b: PERIOD=32, manual start just before the first tick -> one overrun
    ifb.sensors_data_i = {8'd61, 8'd50, 8'd0, 8'd100, 8'd0};
    ifb.sensors_en_i   = 5'b11010;
    p = ecnt;
    ifb.auto_en_i = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    qb.push_back(model(ifb.sensors_data_i, ifb.sensors_en_i, ecnt + 1));
    ifb.start_i = 1'b1;
    @(posedge clk); #1;
    ifb.start_i = 1'b0;
    qb.push_back(model(ifb.sensors_data_i, ifb.sensors_en_i, p + 64));
    for (int i = 0; i < 200; i++) begin
      if (ecnt >= p + 70) break;
      @(posedge clk); #1;
    end
    ifb.auto_en_i = 1'b0;
    wait_idle_b("idle_b");
    chk("b_overrun_count", ov_b_cnt, 1);
    chk("b_overrun_edge", ov_b_edge, p + 32);

    // 6: reset during DIVIDE aborts with no valid, then a clean sample
    ifa.sensors_data_i = {8'd28, 8'd26, 8'd24, 8'd22, 8'd20};
    ifa.sensors_en_i   = 5'b11111;
    start_a(1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", ifa.busy_o, 0);
    chk("abort_valid", ifa.valid_o, 0);
    chk("abort_temp_q", ifa.temp_q_o, 0);
    chk("abort_temp_r", ifa.temp_r_o, 0);
    chk("abort_nr_active", ifa.nr_active_o, 0);
    chk("abort_no_sensor", ifa.no_sensor_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    start_a(1'b1);
    wait_idle_a("idle_s6");
    repeat (3) @(posedge clk);
    #1;

    chk("a_results_all_seen", qa.size(), 0);
    chk("b_results_all_seen", qb.size(), 0);
    chk("a_no_overrun", ov_a_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/temperature_sample_ctrl.md
Name: temperature_sample_ctrl

Overview:
Sequencing controller for the greenhouse temperature datapath. It snapshots the five sensor readings and enables, either on request or on a periodic tick, and accumulates the enabled readings serially. It then runs an iterative 16-bit divide to produce the average quotient and remainder. Results are registered and presented with a one-cycle valid strobe to the LED/alert display stage.

Parameters:
NR_SENSORS, 5, number of sensor channels
DATA_W, 8, width of one sensor reading
SUM_W, 16, accumulator / dividend / quotient / remainder width
PERIOD, 1000, clock cycles between automatic samples; must be >= 32 (elaboration check)

Ports:
clk_i  input  1  system clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
sensors_data_i  input  40  sensor k occupies bits [8k+7:8k]
sensors_en_i  input  5  bit k = 1 means sensor k is active
start_i  input  1  manual sample request, level-sampled in IDLE
auto_en_i  input  1  enables the periodic sample tick
busy_o  output  1  high in every state except IDLE
valid_o  output  1  one-cycle strobe; new results are valid
temp_q_o  output  16  average quotient (sum / active count)
temp_r_o  output  16  average remainder
nr_active_o  output  8  active sensor count of the last sample
no_sensor_o  output  1  last sample had zero active sensors
overrun_o  output  1  one-cycle pulse: periodic tick dropped because the block was busy

Behaviour:
- Reset (asynchronous, any state): state=IDLE, period counter=0, all outputs=0. Aborts any operation in flight; no valid_o is issued.
- Period counter:
  - When auto_en_i=1, it counts 0..PERIOD-1 and wraps; tick = (count == PERIOD-1).
  - When auto_en_i=0, it is held at 0 and no tick is generated.
  - It keeps running while busy.
- Trigger (IDLE only): start_i | tick. Simultaneous start_i and tick produce a single sample.
- start_i while busy is ignored, not queued.
- Tick while busy: pulse overrun_o for one cycle and drop the tick.
- FSM (state register; edge 0 = the edge that samples the trigger):
  - IDLE -> CAPTURE on trigger.
  - CAPTURE (1 cycle): latch sensors_data_i and sensors_en_i into snapshot registers; clear sum and count. Input changes after this edge have no effect on the result.
  - ACCUM (NR_SENSORS cycles, idx 0..4): if snap_en[idx], then sum += zero-extended data[idx] and count += 1.
  - After idx 4: if count == 0, go to DONE with Q=0, R=0, no_sensor=1. Otherwise go to DIVIDE.
  - DIVIDE (SUM_W = 16 cycles): restoring shift-subtract of sum by the zero-extended count, one quotient bit per cycle, MSB first.
  - DONE (1 cycle): valid_o=1; return to IDLE.
- Output update: temp_q_o, temp_r_o, nr_active_o and no_sensor_o update on the edge entering DONE. They hold until the next DONE or reset.
- Latency:
  - Normal case: valid_o is high in the cycle after edge 22.
  - Zero-sensor case: valid_o is high in the cycle after edge 6.
  - busy_o is high from edge 0 until the edge that returns to IDLE.
- Arithmetic:
  - Maximum sum is 5*255 = 1275, which cannot overflow 16 bits.
  - The quotient is always <= 255.
  - The remainder is always < count.

Decomposition:
- Package temp_pkg: NR_SENSORS, DATA_W, SUM_W, the state enum (IDLE, CAPTURE, ACCUM, DIVIDE, DONE), and a sensor-slice helper function.
- Sub-module serial_divider: 16-bit restoring divider with start/done handshake and fixed 16-cycle latency. It is instantiated once and driven from the DIVIDE state.

Test Plan:
1. Enable all sensors, data 20,22,24,26,28; pulse start_i -> valid_o in the cycle after edge 22; q=24, r=0, nr_active=5, no_sensor=0.
2. en=5'b00101, s0=25, s2=30 -> q=27, r=1, nr_active=2.
3. en=0; pulse start_i -> valid_o after edge 6; q=0, r=0, nr_active=0, no_sensor=1.
4. All en, all data 255; change data to 0 at edge 2 -> q=255, r=0 (snapshot held).
5. PERIOD=40, auto_en_i=1 -> valid_o every 40 cycles. start_i mid-operation -> no extra sample. With PERIOD=32 and a manual start just before a tick -> overrun_o pulses once.
6. Drop rst_ni during DIVIDE (edge 10) -> outputs 0 immediately, no valid_o. Release reset, run scenario 1 -> correct result.
